bram_burst_reader: RTL and testbench

Read-side initiator for a single BRAM port in the imaging pipeline. It takes a command (start address, length), issues one BRAM read per cycle with fixed BRAM read latency, and delivers the returned words in order on a valid/ready stream with `tlast`. An internal credit-limited FIFO absorbs downstream backpressure so no in-flight BRAM data is ever lost. It drives the same port signal set that `ips_bram` exposes (ena/wea/addr/din/dout) and is verified against that model.

---
 rtl/bram_rd_pkg.sv | 19 +
 rtl/bram_rd_fifo.sv | 65 ++++++
 rtl/bram_burst_reader.sv | 165 ++++++++++++++++
 tb/tb_bram_burst_reader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_rd_pkg.sv
// Shared types and sizing helpers for the BRAM burst reader.
// The FSM state encoding is exported so checkers can bind to it directly.
package bram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int NB_FIFO_DEP_DEF = 8;
  localparam int WD_FIFO_CNT     = $clog2(NB_FIFO_DEP_DEF) + 1;

  // Occupancy counters need one extra bit to represent a completely full FIFO.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// Synchronous return FIFO for BRAM read data; head is visible combinationally.
// Power-of-two depth so the pointers wrap naturally.
module bram_rd_fifo #(
  parameter int WD     = 33,
  parameter int DEP    = 8,
  parameter int WD_CNT = $clog2(DEP) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WD-1:0]     wdata,
  input  logic              pop,
  output logic [WD-1:0]     rdata,
  output logic              full,
  output logic              empty,
  output logic [WD_CNT-1:0] count
);

  localparam int WD_PTR = $clog2(DEP);

  logic [WD-1:0]     mem_q [DEP];
  logic [WD_PTR-1:0] wr_ptr_q, wr_ptr_d;
  logic [WD_PTR-1:0] rd_ptr_q, rd_ptr_d;
  logic [WD_CNT-1:0] cnt_q, cnt_d;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt_q == WD_CNT'(DEP));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + WD_PTR'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + WD_PTR'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + WD_CNT'(1);
      2'b01:   cnt_d = cnt_q - WD_CNT'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/bram_burst_reader.sv
// Burst read initiator for one BRAM port: issues one read per cycle under a
// credit limit and streams the returned words out in order with tlast.
module bram_burst_reader
  import bram_rd_pkg::*;
#(
  parameter int NB_BRAM_DLY = 2,
  parameter int WD_BRAM_ADR = 8,
  parameter int WD_BRAM_DAT = 32,
  parameter int NB_FIFO_DEP = 8
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rst,
  input  logic                   s_cmd_valid,
  output logic                   s_cmd_ready,
  input  logic [WD_BRAM_ADR-1:0] s_cmd_addr,
  input  logic [WD_BRAM_ADR-1:0] s_cmd_len,
  output logic                   m_bram_ena,
  output logic                   m_bram_wea,
  output logic [WD_BRAM_ADR-1:0] m_bram_addra,
  output logic [WD_BRAM_DAT-1:0] m_bram_dina,
  input  logic [WD_BRAM_DAT-1:0] m_bram_douta,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [WD_BRAM_DAT-1:0] m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [1:0]             o_dbg_state
);

  // Handshake rule for both streams: a transfer happens on a rising edge where
  // valid and ready are both high; valid never depends on ready.

  localparam int WD_CNT = cnt_width(NB_FIFO_DEP);
  localparam int WD_ENT = WD_BRAM_DAT + 1;

  state_t                   state_q, state_d;
  logic [WD_BRAM_ADR-1:0]   addr_q, addr_d;
  logic [WD_BRAM_ADR-1:0]   rem_q, rem_d;
  logic [NB_BRAM_DLY-1:0]   vld_sr_q, vld_sr_d;
  logic [NB_BRAM_DLY-1:0]   lst_sr_q, lst_sr_d;
  logic                     done_q, done_d;

  logic                     cmd_fire;
  logic                     issue;
  logic                     last_issue;
  logic                     pop;
  logic                     push;
  logic                     credit_ok;
  logic [WD_CNT-1:0]        inflight;
  logic [WD_CNT:0]          outstanding;

  logic [WD_ENT-1:0]        fifo_wdata;
  logic [WD_ENT-1:0]        fifo_rdata;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [WD_CNT-1:0]        fifo_cnt;

  // Credits: reads in the latency pipe plus words already parked in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < NB_BRAM_DLY; i++) begin
      inflight = inflight + {{(WD_CNT-1){1'b0}}, vld_sr_q[i]};
    end
  end

  assign outstanding = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign credit_ok   = (outstanding < (WD_CNT+1)'(NB_FIFO_DEP));

  assign cmd_fire   = s_cmd_valid & s_cmd_ready;
  assign issue      = m_bram_ena;
  assign last_issue = issue & (rem_q == '0);
  assign pop        = m_axis_tvalid & m_axis_tready;
  assign push       = vld_sr_q[NB_BRAM_DLY-1];

  // FSM: state register
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_fire)            state_d = ISSUE;
      ISSUE:   if (last_issue)          state_d = DRAIN;
      DRAIN:   if (pop && m_axis_tlast) state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    s_cmd_ready = (state_q == IDLE);
    o_busy      = (state_q != IDLE);
    m_bram_ena  = (state_q == ISSUE) && credit_ok;
  end

  assign o_dbg_state = state_q;

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (cmd_fire) begin
      addr_d = s_cmd_addr;
      rem_d  = s_cmd_len;
    end else if (issue) begin
      addr_d = addr_q + WD_BRAM_ADR'(1);
      rem_d  = rem_q - WD_BRAM_ADR'(1);
    end
    vld_sr_d[0] = issue;
    lst_sr_d[0] = last_issue;
    for (int i = 1; i < NB_BRAM_DLY; i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
      lst_sr_d[i] = lst_sr_q[i-1];
    end
    done_d = pop & m_axis_tlast;
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      addr_q   <= '0;
      rem_q    <= '0;
      vld_sr_q <= '0;
      lst_sr_q <= '0;
      done_q   <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      vld_sr_q <= vld_sr_d;
      lst_sr_q <= lst_sr_d;
      done_q   <= done_d;
    end
  end

  assign fifo_wdata = {lst_sr_q[NB_BRAM_DLY-1], m_bram_douta};

  bram_rd_fifo #(
    .WD     (WD_ENT),
    .DEP    (NB_FIFO_DEP),
    .WD_CNT (WD_CNT)
  ) u_fifo (
    .clk   (i_sys_clk),
    .rst   (i_sys_rst),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Stream fields are forced to zero while empty so reset leaves them clean.
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_rdata[WD_BRAM_DAT-1:0];
  assign m_axis_tlast  = ~fifo_empty & fifo_rdata[WD_BRAM_DAT];

  assign m_bram_wea   = 1'b0;
  assign m_bram_dina  = '0;
  assign m_bram_addra = addr_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_bram_burst_reader.sv
// Bench for bram_burst_reader with a behavioural BRAM (word = addr*3) and an
// in-order scoreboard of expected {tlast, tdata} beats.
module tb_bram_burst_reader;

  localparam int DLY = 2;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int DEP = 8;

  logic          i_sys_clk;
  logic          i_sys_rst;
  logic          s_cmd_valid;
  logic          s_cmd_ready;
  logic [AW-1:0] s_cmd_addr;
  logic [AW-1:0] s_cmd_len;
  logic          m_bram_ena;
  logic          m_bram_wea;
  logic [AW-1:0] m_bram_addra;
  logic [DW-1:0] m_bram_dina;
  logic [DW-1:0] m_bram_douta;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          o_busy;
  logic          o_done;
  logic [1:0]    o_dbg_state;

  bram_burst_reader #(
    .NB_BRAM_DLY (DLY),
    .WD_BRAM_ADR (AW),
    .WD_BRAM_DAT (DW),
    .NB_FIFO_DEP (DEP)
  ) dut (
    .i_sys_clk     (i_sys_clk),
    .i_sys_rst     (i_sys_rst),
    .s_cmd_valid   (s_cmd_valid),
    .s_cmd_ready   (s_cmd_ready),
    .s_cmd_addr    (s_cmd_addr),
    .s_cmd_len     (s_cmd_len),
    .m_bram_ena    (m_bram_ena),
    .m_bram_wea    (m_bram_wea),
    .m_bram_addra  (m_bram_addra),
    .m_bram_dina   (m_bram_dina),
    .m_bram_douta  (m_bram_douta),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_dbg_state   (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_sys_clk = 1'b0;
  always #5 i_sys_clk = ~i_sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- BRAM model ----------------
  logic [DW-1:0] mem [256];
  logic [DW-1:0] pipe [DLY];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'd3;
  end

  always @(posedge i_sys_clk) begin
    if (m_bram_ena && m_bram_wea) mem[m_bram_addra] <= m_bram_dina;
    if (m_bram_ena && !m_bram_wea) pipe[0] <= mem[m_bram_addra];
    for (int i = 1; i < DLY; i++) pipe[i] <= pipe[i-1];
  end
  assign m_bram_douta = pipe[DLY-1];

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] addr_log[$];
  int ena_cnt  = 0;
  int beat_cnt = 0;
  int out_cnt  = 0;
  int max_out  = 0;
  int viol     = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge i_sys_clk) begin
    logic [DW:0] e;
    if (i_sys_rst) begin
      out_cnt = 0;
    end else begin
      if (m_bram_ena) begin
        ena_cnt++;
        addr_log.push_back(m_bram_addra);
        if (out_cnt >= DEP) viol++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          check_val("unexpected_beat", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check_val("tdata", 64'(m_axis_tdata), 64'(e[DW-1:0]));
          check_val("tlast", 64'(m_axis_tlast), 64'(e[DW]));
        end
      end
      out_cnt = out_cnt + (m_bram_ena ? 1 : 0) - ((m_axis_tvalid && m_axis_tready) ? 1 : 0);
      if (out_cnt > max_out) max_out = out_cnt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_sys_clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check_val("rst_cmd_ready", 64'(s_cmd_ready),   64'd1);
    check_val("rst_ena",       64'(m_bram_ena),    64'd0);
    check_val("rst_wea",       64'(m_bram_wea),    64'd0);
    check_val("rst_addra",     64'(m_bram_addra),  64'd0);
    check_val("rst_dina",      64'(m_bram_dina),   64'd0);
    check_val("rst_tvalid",    64'(m_axis_tvalid), 64'd0);
    check_val("rst_tlast",     64'(m_axis_tlast),  64'd0);
    check_val("rst_tdata",     64'(m_axis_tdata),  64'd0);
    check_val("rst_busy",      64'(o_busy),        64'd0);
    check_val("rst_done",      64'(o_done),        64'd0);
  endtask

  // Queues the expected beats, then holds the command until it is accepted.
  // Returns at #1 after the accepting edge; done_seen is o_done in that cycle.
  task automatic send_cmd(input logic [AW-1:0] a, input logic [AW-1:0] l, output logic done_seen);
    logic [DW:0]   e;
    logic [AW-1:0] ad;
    logic          acc;
    int            n;
    for (int i = 0; i <= int'(l); i++) begin
      ad = a + AW'(i);
      e  = {(i == int'(l)), 32'(ad) * 32'd3};
      exp_q.push_back(e);
    end
    s_cmd_valid = 1'b1;
    s_cmd_addr  = a;
    s_cmd_len   = l;
    acc = 1'b0;
    done_seen = 1'b0;
    n = 0;
    while (!acc && n < 300) begin
      @(negedge i_sys_clk);
      acc = s_cmd_ready;
      done_seen = o_done;
      tick();
      n++;
    end
    s_cmd_valid = 1'b0;
    check_val("cmd_accept", 64'(acc), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((o_busy || m_axis_tvalid) && n < 1000) begin
      tick();
      n++;
    end
    check_val("idle_timeout", 64'(n < 1000), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic dn;
    int   k, first_k, last_k, base;
    i_sys_rst     = 1'b1;
    s_cmd_valid   = 1'b0;
    s_cmd_addr    = '0;
    s_cmd_len     = '0;
    m_axis_tready = 1'b1;
    repeat (3) tick();
    check_reset_outputs();
    i_sys_rst = 1'b0;
    tick();

    // Single beat: latency of tvalid and o_done timing.
    send_cmd(8'd5, 8'd0, dn);
    check_val("single_ena",  64'(m_bram_ena),   64'd1);
    check_val("single_addr", 64'(m_bram_addra), 64'd5);
    k = 0;
    while (!m_axis_tvalid && k < 50) begin tick(); k++; end
    check_val("single_lat", 64'(k), 64'd3);
    check_val("single_done_early", 64'(o_done), 64'd0);
    tick();
    check_val("single_done", 64'(o_done), 64'd1);
    check_val("single_busy", 64'(o_busy), 64'd0);
    tick();
    check_val("single_done_pulse", 64'(o_done), 64'd0);

    // Burst with tready held high: no bubbles, exact ena count.
    wait_idle();
    ena_cnt = 0; base = beat_cnt;
    send_cmd(8'h10, 8'd15, dn);
    k = 0; first_k = -1; last_k = -1;
    while (last_k < 0 && k < 100) begin
      tick(); k++;
      if (m_axis_tvalid && first_k < 0) first_k = k;
      if (m_axis_tvalid && m_axis_tlast) last_k = k;
    end
    check_val("burst_first_lat", 64'(first_k), 64'd3);
    check_val("burst_last_lat",  64'(last_k), 64'(15 + DLY + 1));
    wait_idle();
    check_val("burst_ena_cnt", 64'(ena_cnt), 64'd16);
    check_val("burst_beats",   64'(beat_cnt - base), 64'd16);

    // Backpressure mid-burst.
    ena_cnt = 0; max_out = 0; viol = 0;
    send_cmd(8'h40, 8'd31, dn);
    repeat (4) tick();
    m_axis_tready = 1'b0;
    repeat (20) tick();
    check_val("bp_ena_stalled", 64'(m_bram_ena), 64'd0);
    check_val("bp_tvalid", 64'(m_axis_tvalid), 64'd1);
    m_axis_tready = 1'b1;
    tick();
    check_val("bp_ena_resume", 64'(m_bram_ena), 64'd1);
    wait_idle();
    check_val("bp_max_outstanding", 64'(max_out), 64'(DEP));
    check_val("bp_credit_viol", 64'(viol), 64'd0);
    check_val("bp_ena_cnt", 64'(ena_cnt), 64'd32);

    // Address wrap.
    addr_log.delete();
    send_cmd(8'hFE, 8'd3, dn);
    wait_idle();
    check_val("wrap_n_addr", 64'(addr_log.size()), 64'd4);
    if (addr_log.size() == 4) begin
      check_val("wrap_a0", 64'(addr_log[0]), 64'hFE);
      check_val("wrap_a1", 64'(addr_log[1]), 64'hFF);
      check_val("wrap_a2", 64'(addr_log[2]), 64'h00);
      check_val("wrap_a3", 64'(addr_log[3]), 64'h01);
    end

    // Reset mid-burst at beat 5, then a clean short burst.
    base = beat_cnt;
    send_cmd(8'h80, 8'd15, dn);
    k = 0;
    while ((beat_cnt - base) < 5 && k < 100) begin tick(); k++; end
    check_val("rst_mid_reached", 64'(beat_cnt - base), 64'd5);
    i_sys_rst = 1'b1;
    #1;
    check_reset_outputs();
    exp_q.delete();
    ena_cnt = 0;
    s_cmd_valid = 1'b1;
    s_cmd_addr  = 8'd0;
    s_cmd_len   = 8'd1;
    repeat (2) begin
      tick();
      check_val("rst_hold_busy",  64'(o_busy),      64'd0);
      check_val("rst_hold_ready", 64'(s_cmd_ready), 64'd1);
    end
    s_cmd_valid = 1'b0;
    i_sys_rst = 1'b0;
    tick();
    check_val("rst_hold_ena_cnt", 64'(ena_cnt), 64'd0);
    base = beat_cnt;
    send_cmd(8'd0, 8'd1, dn);
    wait_idle();
    repeat (10) tick();
    check_val("post_rst_beats", 64'(beat_cnt - base), 64'd2);
    check_val("post_rst_ena",   64'(ena_cnt), 64'd2);

    // Command presented while busy is held off, then taken with o_done.
    base = beat_cnt;
    send_cmd(8'h20, 8'd7, dn);
    check_val("busy_flag", 64'(o_busy), 64'd1);
    check_val("busy_ready", 64'(s_cmd_ready), 64'd0);
    send_cmd(8'h30, 8'd3, dn);
    check_val("busy_accept_with_done", 64'(dn), 64'd1);
    wait_idle();
    check_val("busy_beats", 64'(beat_cnt - base), 64'd12);

    repeat (5) tick();
    check_val("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
